// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit and its next-PC calculator.
package pc_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    // NextPCSrc encodings
    localparam logic [1:0] PC4    = 2'b00;
    localparam logic [1:0] BRANCH = 2'b01;
    localparam logic [1:0] JALR   = 2'b10;
    localparam logic [1:0] JAL    = 2'b11;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC target selection and alignment check.
// All additions wrap modulo 2^32; JALR clears bit 0 before the check.
module pc_next_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] apc,
    input  logic [1:0]  next_pc_src,
    input  logic        br_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] target,
    output logic        target_misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] reg_pc;

    assign seq_pc = apc + 32'd4;
    assign rel_pc = apc + imm;
    assign reg_pc = rs1 + imm;

    // Pick the target for the current control-flow kind
    always_comb begin
        target = seq_pc;
        case (next_pc_src)
            PC4:     target = seq_pc;
            BRANCH:  target = br_taken ? rel_pc : seq_pc;
            JALR:    target = {reg_pc[31:1], 1'b0};
            JAL:     target = rel_pc;
            default: target = seq_pc;
        endcase
    end

    assign target_misaligned = |target[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus BOOT/FETCH/EXEC/TRAP sequencer driving the instruction fetch.
// Handshake outputs are decoded from the state, so reset clears them at once.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [1:0]  NextPCSrc,
    input  logic [31:0] Imm,
    input  logic [31:0] Rs1,
    input  logic        ImemAck,
    output logic        ImemReq,
    output logic [31:0] Apc,
    output logic [31:0] PcPlus4,
    output logic        Ivalid,
    output logic        Misaligned
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  apc_q;
    logic [31:0]  apc_d;
    logic [31:0]  target;
    logic         target_misaligned;

    pc_next_calc u_next (
        .apc               (apc_q),
        .next_pc_src       (NextPCSrc),
        .br_taken          (BrTaken),
        .imm               (Imm),
        .rs1               (Rs1),
        .target            (target),
        .target_misaligned (target_misaligned)
    );

    // State and PC registers; reset discards any pending fetch or update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            apc_q   <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            apc_q   <= apc_d;
        end
    end

    // Next state, next PC and per-state handshake outputs
    always_comb begin
        state_d    = state_q;
        apc_d      = apc_q;
        ImemReq    = 1'b0;
        Ivalid     = 1'b0;
        Misaligned = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                ImemReq = 1'b1;
                if (ImemAck) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                Ivalid = 1'b1;
                if (!Stall) begin
                    if (target_misaligned) begin
                        state_d = TRAP;
                    end else begin
                        apc_d   = target;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: begin
                Misaligned = 1'b1;
                apc_d      = TRAP_VECTOR;
                state_d    = FETCH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign Apc     = apc_q;
    assign PcPlus4 = apc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed PC values.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        BrTaken;
    logic [1:0]  NextPCSrc;
    logic [31:0] Imm;
    logic [31:0] Rs1;
    logic        ImemAck;
    logic        ImemReq;
    logic [31:0] Apc;
    logic [31:0] PcPlus4;
    logic        Ivalid;
    logic        Misaligned;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .BrTaken    (BrTaken),
        .NextPCSrc  (NextPCSrc),
        .Imm        (Imm),
        .Rs1        (Rs1),
        .ImemAck    (ImemAck),
        .ImemReq    (ImemReq),
        .Apc        (Apc),
        .PcPlus4    (PcPlus4),
        .Ivalid     (Ivalid),
        .Misaligned (Misaligned)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] src, input logic br, input logic [31:0] imm_v,
                                 input logic [31:0] rs1_v, input logic stall_v, input logic ack_v);
        NextPCSrc = src;
        BrTaken   = br;
        Imm       = imm_v;
        Rs1       = rs1_v;
        Stall     = stall_v;
        ImemAck   = ack_v;
    endtask

    // From FETCH with an immediate ack: enter EXEC, apply one instruction, check the new PC
    task automatic execOne(input string tag, input logic [1:0] src, input logic br,
                           input logic [31:0] imm_v, input logic [31:0] rs1_v, input logic [31:0] exp_pc);
        applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput({tag, "_ivalid"}, {31'b0, Ivalid}, 32'd1);
        applyStimulus(src, br, imm_v, rs1_v, 1'b0, 1'b1);
        tick();
        checkOutput({tag, "_apc"}, Apc, exp_pc);
        checkOutput({tag, "_req"}, {31'b0, ImemReq}, 32'd1);
    endtask

    initial begin
        $display("[TB] pc_fetch_unit directed test");
        rst = 1'b1;
        applyStimulus(2'b00, 1'b1, 32'h0000_0010, 32'h0000_0004, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_apc", Apc, 32'h0000_0000);
        checkOutput("rst_pcplus4", PcPlus4, 32'h0000_0004);
        checkOutput("rst_req", {31'b0, ImemReq}, 32'd0);
        checkOutput("rst_ivalid", {31'b0, Ivalid}, 32'd0);
        checkOutput("rst_mis", {31'b0, Misaligned}, 32'd0);

        // Release reset: one BOOT cycle, then FETCH
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("boot_req", {31'b0, ImemReq}, 32'd1);
        checkOutput("boot_apc", Apc, 32'h0000_0000);
        checkOutput("boot_ivalid", {31'b0, Ivalid}, 32'd0);
        tick();
        checkOutput("exec0_ivalid", {31'b0, Ivalid}, 32'd1);
        checkOutput("exec0_req", {31'b0, ImemReq}, 32'd0);
        tick();
        checkOutput("seq_apc4", Apc, 32'h0000_0004);
        execOne("seq8", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0008);
        execOne("seqC", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_000C);
        execOne("seq10", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0010);

        // Branches and JAL
        execOne("br_taken", 2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0000_0008);
        execOne("jal", 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0010);
        execOne("br_not", 2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_0014);

        // JALR aligned after bit-0 clear
        execOne("jalr_ok", 2'b10, 1'b0, 32'h0000_0003, 32'h0000_1001, 32'h0000_1004);
        checkOutput("jalr_ok_mis", {31'b0, Misaligned}, 32'd0);

        // JALR misaligned -> TRAP -> TRAP_VECTOR
        applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b10, 1'b0, 32'h0000_0001, 32'h0000_1001, 1'b0, 1'b1);
        tick();
        checkOutput("trap_mis", {31'b0, Misaligned}, 32'd1);
        checkOutput("trap_req", {31'b0, ImemReq}, 32'd0);
        checkOutput("trap_ivalid", {31'b0, Ivalid}, 32'd0);
        tick();
        checkOutput("trap_apc", Apc, 32'h0000_0100);
        checkOutput("trap_mis_end", {31'b0, Misaligned}, 32'd0);
        checkOutput("trap_fetch", {31'b0, ImemReq}, 32'd1);

        // Stall holds EXEC for three cycles, then one update
        tick();
        applyStimulus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_ivalid", {31'b0, Ivalid}, 32'd1);
            checkOutput("stall_apc", Apc, 32'h0000_0100);
        end
        Stall = 1'b0;
        tick();
        checkOutput("unstall_apc", Apc, 32'h0000_0104);
        checkOutput("unstall_ivalid", {31'b0, Ivalid}, 32'd0);

        // No ack: FETCH holds, Stall ignored
        applyStimulus(2'b11, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("wait_req", {31'b0, ImemReq}, 32'd1);
        checkOutput("wait_apc", Apc, 32'h0000_0104);
        checkOutput("wait_ivalid", {31'b0, Ivalid}, 32'd0);

        // Wrap-around at the top of the address space
        execOne("to_top", 2'b11, 1'b0, 32'hFFFF_FEF8, 32'h0, 32'hFFFF_FFFC);
        checkOutput("top_pcplus4", PcPlus4, 32'h0000_0000);
        execOne("wrap", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0000);
        checkOutput("wrap_mis", {31'b0, Misaligned}, 32'd0);
        execOne("pre_rst", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0004);

        // Reset in FETCH with ack in the same cycle
        rst = 1'b1;
        ImemAck = 1'b1;
        tick();
        checkOutput("rstf_apc", Apc, 32'h0000_0000);
        checkOutput("rstf_req", {31'b0, ImemReq}, 32'd0);
        checkOutput("rstf_ivalid", {31'b0, Ivalid}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("rstf_boot_ivalid", {31'b0, Ivalid}, 32'd0);
        checkOutput("rstf_boot_req", {31'b0, ImemReq}, 32'd1);

        // Reset in EXEC abandons the pending PC update
        tick();
        checkOutput("rste_ivalid", {31'b0, Ivalid}, 32'd1);
        applyStimulus(2'b11, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("rste_apc", Apc, 32'h0000_0000);
        checkOutput("rste_req", {31'b0, ImemReq}, 32'd0);
        checkOutput("rste_ivalid_off", {31'b0, Ivalid}, 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
